// File: rtl/mpc_seq_pkg.sv
// Shared types and default dimensions for the mpc program sequencer.
package mpc_seq_pkg;

  localparam int unsigned MPC_IW    = 18;
  localparam int unsigned MPC_OW    = 9;
  localparam int unsigned MPC_DEPTH = 16;
  localparam int unsigned MPC_AW    = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_CAPT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/mpc_seq_pbuf.sv
// Program buffer: DEPTH x IW register file, synchronous write, combinational read, no reset.
module mpc_seq_pbuf #(
  parameter int unsigned IW    = 18,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mpc_seq.sv
// Program sequencer for the mpc unit: issues buffered instructions and streams results.
// Optional multi-pass looping is enabled by defining MPC_SEQ_LOOP_EN.
module mpc_seq
  import mpc_seq_pkg::*;
#(
  parameter int unsigned IW    = MPC_IW,
  parameter int unsigned OW    = MPC_OW,
  parameter int unsigned DEPTH = MPC_DEPTH,
  parameter int unsigned AW    = MPC_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [IW-1:0] wr_data,
  input  logic          start,
  input  logic [AW:0]   prog_len,
`ifdef MPC_SEQ_LOOP_EN
  input  logic [7:0]    loop_cnt,
`endif
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] mpc_instr,
  input  logic [OW-1:0] mpc_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [OW-1:0] res_data,
  output logic [AW-1:0] res_idx
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   len_q, len_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          rv_q, rv_d;
  logic [OW-1:0] rd_q, rd_d;
  logic [AW-1:0] ri_q, ri_d;
  logic          zdone_q, zdone_d;
  logic          pbuf_we;
  logic [IW-1:0] pbuf_rdata;
  logic          last_pc;
  logic          loops_left;
  logic          hs;
  logic [AW:0]   len_in;

`ifdef MPC_SEQ_LOOP_EN
  logic [7:0] loop_q, loop_d;
  assign loops_left = (loop_q != '0);
`else
  assign loops_left = 1'b0;
`endif

  assign len_in  = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign last_pc = ({1'b0, pc_q} == (len_q - 1'b1));
  assign hs      = rv_q && res_ready;

  mpc_seq_pbuf #(
    .IW    (IW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_pbuf (
    .clk   (clk),
    .we    (pbuf_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (pc_q),
    .rdata (pbuf_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      instr_q <= '0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      ri_q    <= '0;
      zdone_q <= 1'b0;
`ifdef MPC_SEQ_LOOP_EN
      loop_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      instr_q <= instr_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      ri_q    <= ri_d;
      zdone_q <= zdone_d;
`ifdef MPC_SEQ_LOOP_EN
      loop_q  <= loop_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start && (prog_len != '0)) state_d = S_ISSUE;
      S_ISSUE: state_d = S_CAPT;
      S_CAPT:  state_d = S_HOLD;
      S_HOLD:  if (hs) state_d = (last_pc && !loops_left) ? S_DONE : S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // abort dominates everything, including a start seen in the same IDLE cycle
    if (abort) state_d = S_IDLE;
  end

  always_comb begin
    pc_d    = pc_q;
    len_d   = len_q;
    instr_d = instr_q;
    rv_d    = rv_q;
    rd_d    = rd_q;
    ri_d    = ri_q;
    zdone_d = 1'b0;
`ifdef MPC_SEQ_LOOP_EN
    loop_d  = loop_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (prog_len == '0) begin
            zdone_d = 1'b1;
          end else begin
            len_d = len_in;
            pc_d  = '0;
`ifdef MPC_SEQ_LOOP_EN
            loop_d = loop_cnt;
`endif
          end
        end
      end
      S_ISSUE: instr_d = pbuf_rdata;
      S_CAPT: begin
        rd_d = mpc_out;
        ri_d = pc_q;
        rv_d = 1'b1;
      end
      S_HOLD: begin
        if (hs) begin
          rv_d = 1'b0;
          if (!last_pc) begin
            pc_d = pc_q + AW'(1);
          end else if (loops_left) begin
            pc_d = '0;
`ifdef MPC_SEQ_LOOP_EN
            loop_d = loop_q - 8'd1;
`endif
          end
        end
      end
      default: ;
    endcase
    if (abort && (state_q != S_IDLE)) begin
      rv_d = 1'b0;
      pc_d = '0;
    end
  end

  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE) || zdone_q;
    pbuf_we = wr_en && (state_q == S_IDLE);
  end

  assign mpc_instr = instr_q;
  assign res_valid = rv_q;
  assign res_data  = rd_q;
  assign res_idx   = ri_q;

endmodule

// File: tb/tb_mpc_seq.sv
// Directed self-checking bench for mpc_seq with a behavioural stand-in for the mpc unit.
// Define MPC_SEQ_LOOP_EN to also exercise multi-pass runs.
module tb_mpc_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [17:0] wr_data;
  logic        start;
  logic [4:0]  prog_len;
`ifdef MPC_SEQ_LOOP_EN
  logic [7:0]  loop_cnt;
`endif
  logic        abort;
  logic        busy;
  logic        done;
  logic [17:0] mpc_instr;
  logic [8:0]  mpc_out;
  logic        res_valid;
  logic        res_ready;
  logic [8:0]  res_data;
  logic [3:0]  res_idx;

  int n_checks = 0;
  int n_errors = 0;
  int last_wait;

  always #5 clk = ~clk;

  // mpc stand-in: out = instr[17:9] + instr[8:0], truncated to 9 bits
  function automatic logic [8:0] mpc_ref(input logic [17:0] i);
    return i[17:9] + i[8:0];
  endfunction

  always_comb mpc_out = mpc_ref(mpc_instr);

  mpc_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .prog_len  (prog_len),
`ifdef MPC_SEQ_LOOP_EN
    .loop_cnt  (loop_cnt),
`endif
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .mpc_instr (mpc_instr),
    .mpc_out   (mpc_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_idx   (res_idx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [17:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic run(input logic [4:0] len);
    start = 1'b1; prog_len = len;
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid();
    last_wait = 0;
    while (!res_valid && last_wait < 20) begin
      step();
      last_wait++;
    end
    check("valid", {31'd0, res_valid}, 32'd1);
  endtask

  task automatic expect_result(input logic [3:0] idx, input logic [8:0] data,
                               input int stall, input bit last);
    wait_valid();
    check("idx", {28'd0, res_idx}, {28'd0, idx});
    check("data", {23'd0, res_data}, {23'd0, data});
    check("busy_run", {31'd0, busy}, 32'd1);
    for (int k = 0; k < stall; k++) begin
      step();
      check("stall_valid", {31'd0, res_valid}, 32'd1);
      check("stall_idx", {28'd0, res_idx}, {28'd0, idx});
      check("stall_data", {23'd0, res_data}, {23'd0, data});
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("valid_drop", {31'd0, res_valid}, 32'd0);
    check("done_pulse", {31'd0, done}, {31'd0, last});
    if (last) begin
      step();
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("idle_after", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; prog_len = '0; abort = 1'b0; res_ready = 1'b0;
`ifdef MPC_SEQ_LOOP_EN
    loop_cnt = '0;
`endif
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_valid", {31'd0, res_valid}, 32'd0);
    check("rst_instr", {14'd0, mpc_instr}, 32'd0);
    check("rst_data", {23'd0, res_data}, 32'd0);
    check("rst_idx", {28'd0, res_idx}, 32'd0);
    #10 rst_n = 1'b1;
    step();

    load(4'd0, 18'h00701);
    load(4'd1, 18'h00000);
    load(4'd2, 18'h3FFFF);
    load(4'd3, 18'h12345);

    // basic run with exact first-result latency
    run(5'd3);
    check("busy_start", {31'd0, busy}, 32'd1);
    step();
    check("lat_capt", {31'd0, res_valid}, 32'd0);
    expect_result(4'd0, 9'h104, 0, 1'b0);
    check("latency", last_wait, 32'd1);
    check("instr0", {14'd0, mpc_instr}, 32'h00701);
    expect_result(4'd1, 9'h000, 0, 1'b0);
    expect_result(4'd2, 9'h1FE, 0, 1'b1);
    check("instr_kept", {14'd0, mpc_instr}, 32'h3FFFF);

    // backpressure on idx 1
    run(5'd3);
    expect_result(4'd0, 9'h104, 0, 1'b0);
    expect_result(4'd1, 9'h000, 5, 1'b0);
    expect_result(4'd2, 9'h1FE, 0, 1'b1);

    // zero-length run
    run(5'd0);
    check("zlen_done", {31'd0, done}, 32'd1);
    check("zlen_busy", {31'd0, busy}, 32'd0);
    step();
    check("zlen_done_end", {31'd0, done}, 32'd0);
    check("zlen_busy2", {31'd0, busy}, 32'd0);
    check("zlen_valid", {31'd0, res_valid}, 32'd0);

    // abort in HOLD of idx 1, then a fresh run starts at idx 0
    run(5'd4);
    expect_result(4'd0, 9'h104, 0, 1'b0);
    wait_valid();
    check("abort_idx", {28'd0, res_idx}, 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_valid", {31'd0, res_valid}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    step();
    check("abort_done2", {31'd0, done}, 32'd0);
    run(5'd4);
    expect_result(4'd0, 9'h104, 0, 1'b0);
    expect_result(4'd1, 9'h000, 0, 1'b0);
    expect_result(4'd2, 9'h1FE, 0, 1'b0);
    expect_result(4'd3, 9'h1D6, 0, 1'b1);

    // abort together with start in IDLE: no run
    abort = 1'b1;
    run(5'd2);
    abort = 1'b0;
    check("abort_start_busy", {31'd0, busy}, 32'd0);

    // write while busy is ignored
    run(5'd1);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 18'h2AAAA;
    step();
    wr_en = 1'b0;
    expect_result(4'd0, 9'h104, 0, 1'b1);
    run(5'd1);
    expect_result(4'd0, 9'h104, 0, 1'b1);

`ifdef MPC_SEQ_LOOP_EN
    loop_cnt = 8'd2;
    run(5'd2);
    for (int p = 0; p < 3; p++) begin
      expect_result(4'd0, 9'h104, 0, 1'b0);
      expect_result(4'd1, 9'h000, 0, (p == 2));
    end
    loop_cnt = 8'd0;
`endif

    // write and start in the same IDLE cycle: run sees new data
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 18'h00E03;
    run(5'd1);
    wr_en = 1'b0;
    expect_result(4'd0, 9'h00A, 0, 1'b1);

    // asynchronous reset mid-run
    run(5'd3);
    wait_valid();
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_valid", {31'd0, res_valid}, 32'd0);
    check("arst_instr", {14'd0, mpc_instr}, 32'd0);
    check("arst_data", {23'd0, res_data}, 32'd0);
    check("arst_idx", {28'd0, res_idx}, 32'd0);
    #2 rst_n = 1'b1;
    step();
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
